// File: rtl/repeat_stream_n_pkg.sv
// Shared types and helpers for the repeat_stream_n block: FSM state encoding and
// the rule that decides whether the beat following a transfer is the final one.
package repeat_stream_n_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // A stop request forces the next beat to be last; otherwise only a finite run
   // whose remaining count is about to reach its final beat does.
   function automatic logic follow_last(input logic inf,
                                        input logic stop_req,
                                        input logic one_left);
      return stop_req | (~inf & one_left);
   endfunction

endpackage

// File: rtl/repeat_stream_n_repeat_counter.sv
// Down-counter holding the number of beats still owed after the one being presented.
// Loads, decrements (saturating at zero) or holds; flags one and zero.
module repeat_counter #(
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               load,
   input  logic               dec,
   input  logic [COUNT_W-1:0] load_val,
   output logic               is_one,
   output logic               is_zero
);

   logic [COUNT_W-1:0] count;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && !is_zero) begin
         count <= count - 1'b1;
      end
   end

   assign is_zero = (count == '0);
   assign is_one  = (count == COUNT_W'(1));

endmodule

// File: rtl/repeat_stream_n.sv
// Repeats one accepted value as a valid/ready stream of nIn beats (nIn==0 runs until
// stop), marking the final beat and allowing a new value to load on that final beat.
module repeat_stream_n #(
   parameter int WIDTH   = 8,
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   dIn,
   input  logic [COUNT_W-1:0] nIn,
   input  logic               stop,
   output logic [WIDTH-1:0]   sOut,
   output logic               sOut_valid,
   input  logic               sOut_ready,
   output logic               sOut_last,
   output logic               busy
);
   import repeat_stream_n_pkg::*;

   state_t             state;
   state_t             state_next;
   logic               xfer;
   logic               load;
   logic               cnt_dec;
   logic               cnt_is_one;
   logic               cnt_is_zero;
   logic [WIDTH-1:0]   data_q;
   logic               last_q;
   logic               inf_q;
   logic               stop_pend_q;
   logic [COUNT_W-1:0] cnt_load_val;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // in_ready is combinational in RUN so a new value can load on the last beat.
   always_comb begin
      state_next = state;
      sOut_valid = 1'b0;
      busy       = 1'b0;
      in_ready   = 1'b0;
      xfer       = 1'b0;
      load       = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            load     = in_valid;
            if (in_valid) begin
               state_next = RUN;
            end
         end
         RUN: begin
            sOut_valid = 1'b1;
            busy       = 1'b1;
            xfer       = sOut_ready;
            in_ready   = sOut_ready & last_q;
            load       = in_valid & sOut_ready & last_q;
            if (sOut_ready && last_q && !in_valid) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The counter holds beats owed after the presented one, hence nIn-1 on load.
   assign cnt_load_val = nIn - 1'b1;
   assign cnt_dec      = xfer & ~last_q & ~inf_q;

   repeat_counter #(
      .COUNT_W (COUNT_W)
   ) u_counter (
      .clk      (clk),
      .nrst     (nrst),
      .load     (load),
      .dec      (cnt_dec),
      .load_val (cnt_load_val),
      .is_one   (cnt_is_one),
      .is_zero  (cnt_is_zero)
   );

   // During a stall everything here holds; a stop seen then is parked in stop_pend_q.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         data_q      <= '0;
         last_q      <= 1'b0;
         inf_q       <= 1'b0;
         stop_pend_q <= 1'b0;
      end else if (load) begin
         data_q      <= dIn;
         last_q      <= (nIn == COUNT_W'(1));
         inf_q       <= (nIn == '0);
         stop_pend_q <= 1'b0;
      end else if (xfer) begin
         if (last_q) begin
            last_q      <= 1'b0;
            inf_q       <= 1'b0;
            stop_pend_q <= 1'b0;
         end else begin
            last_q      <= follow_last(inf_q, stop | stop_pend_q, cnt_is_one);
            stop_pend_q <= 1'b0;
         end
      end else if (busy && stop && !last_q) begin
         stop_pend_q <= 1'b1;
      end
   end

   assign sOut      = data_q;
   assign sOut_last = last_q;

endmodule

// File: tb/tb_repeat_stream_n.sv
// Bench for repeat_stream_n: table of finite runs plus hand-written sequences for
// infinite/stop, reload, reset and idle-stop cases; beats checked against a queue.
module tb_repeat_stream_n;

   logic       clk;
   logic       nrst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] dIn;
   logic [7:0] nIn;
   logic       stop;
   logic [7:0] sOut;
   logic       sOut_valid;
   logic       sOut_ready;
   logic       sOut_last;
   logic       busy;

   repeat_stream_n #(
      .WIDTH   (8),
      .COUNT_W (8)
   ) dut (
      .clk        (clk),
      .nrst       (nrst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .dIn        (dIn),
      .nIn        (nIn),
      .stop       (stop),
      .sOut       (sOut),
      .sOut_valid (sOut_valid),
      .sOut_ready (sOut_ready),
      .sOut_last  (sOut_last),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } beat_t;

   typedef struct {
      logic [7:0] din;
      logic [7:0] nin;
      int         mode;       // 0: always ready, 1: ready toggles 1,0,.., 2: random
      int         exp_beats;
   } vec_t;

   beat_t      sb[$];
   vec_t       vecs[7];
   int         n_tests;
   int         n_fail;
   logic       prev_stall;
   logic [7:0] prev_data;
   logic       prev_last;
   logic       seen_in_ready;
   int         used;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic observe();
      beat_t b;
      seen_in_ready = in_ready;
      if (prev_stall) begin
         check("stall_valid", 32'(sOut_valid), 32'(1));
         check("stall_data", 32'(sOut), 32'(prev_data));
         check("stall_last", 32'(sOut_last), 32'(prev_last));
      end
      prev_stall = sOut_valid & ~sOut_ready;
      prev_data  = sOut;
      prev_last  = sOut_last;
      if (sOut_valid && sOut_ready) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_beat: got data %0h last %0b, want no beat (t=%0t)", sOut, sOut_last, $time);
         end else begin
            b = sb.pop_front();
            check("beat_data", 32'(sOut), 32'(b.data));
            check("beat_last", 32'(sOut_last), 32'(b.last));
         end
      end
   endtask

   task automatic step();
      #1;
      observe();
      @(negedge clk);
   endtask

   task automatic push_beat(input logic [7:0] d, input logic l);
      beat_t b;
      b.data = d;
      b.last = l;
      sb.push_back(b);
   endtask

   task automatic load_run(input logic [7:0] d, input logic [7:0] n, input int nbeats);
      in_valid   = 1'b1;
      dIn        = d;
      nIn        = n;
      sOut_ready = 1'b1;
      for (int k = 0; k < nbeats; k++) push_beat(d, k == nbeats - 1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic idle_check();
      #1;
      check("idle_valid", 32'(sOut_valid), 32'(0));
      check("idle_last", 32'(sOut_last), 32'(0));
      check("idle_busy", 32'(busy), 32'(0));
      check("idle_in_ready", 32'(in_ready), 32'(1));
      @(negedge clk);
   endtask

   task automatic drain(input int mode, input int max_cyc, output int cyc);
      cyc = 0;
      while (sb.size() > 0 && cyc < max_cyc) begin
         case (mode)
            0:       sOut_ready = 1'b1;
            1:       sOut_ready = (cyc % 2 == 0);
            default: sOut_ready = 1'($urandom_range(0, 1));
         endcase
         step();
         cyc++;
      end
      check("drain_empty", 32'(sb.size()), 32'(0));
      sOut_ready = 1'b1;
      idle_check();
   endtask

   initial begin
      vecs[0] = '{din: 8'd42,  nin: 8'd3,   mode: 0, exp_beats: 3};
      vecs[1] = '{din: 8'h5A,  nin: 8'd4,   mode: 1, exp_beats: 4};
      vecs[2] = '{din: 8'h11,  nin: 8'd1,   mode: 0, exp_beats: 1};
      vecs[3] = '{din: 8'hFF,  nin: 8'd255, mode: 0, exp_beats: 255};
      vecs[4] = '{din: 8'h80,  nin: 8'd5,   mode: 2, exp_beats: 5};
      vecs[5] = '{din: 8'h01,  nin: 8'd2,   mode: 1, exp_beats: 2};
      vecs[6] = '{din: 8'hC3,  nin: 8'd17,  mode: 2, exp_beats: 17};

      n_tests    = 0;
      n_fail     = 0;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_last  = 1'b0;
      nrst       = 1'b0;
      in_valid   = 1'b0;
      dIn        = '0;
      nIn        = '0;
      stop       = 1'b0;
      sOut_ready = 1'b1;

      @(negedge clk);
      #1;
      check("rst_valid", 32'(sOut_valid), 32'(0));
      check("rst_last", 32'(sOut_last), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_in_ready", 32'(in_ready), 32'(1));
      check("rst_data", 32'(sOut), 32'(0));
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);

      // Finite runs from the table.
      for (int i = 0; i < 7; i++) begin
         load_run(vecs[i].din, vecs[i].nin, vecs[i].exp_beats);
         check("load_accept", 32'(seen_in_ready), 32'(1));
         drain(vecs[i].mode, 2000, used);
         if (vecs[i].mode == 0) check("run_cycles", 32'(used), 32'(vecs[i].exp_beats));
      end

      // Infinite run, stop coincident with a transfer.
      load_run(8'd7, 8'd0, 0);
      for (int i = 0; i < 10; i++) begin
         push_beat(8'd7, 1'b0);
         step();
      end
      stop = 1'b1;
      push_beat(8'd7, 1'b0);
      step();
      stop = 1'b0;
      push_beat(8'd7, 1'b1);
      step();
      drain(0, 4, used);

      // Infinite run, stop raised during a stall.
      load_run(8'h44, 8'd0, 0);
      for (int i = 0; i < 2; i++) begin
         push_beat(8'h44, 1'b0);
         step();
      end
      sOut_ready = 1'b0;
      stop       = 1'b1;
      step();
      stop = 1'b0;
      step();
      sOut_ready = 1'b1;
      push_beat(8'h44, 1'b0);
      step();
      push_beat(8'h44, 1'b1);
      step();
      drain(0, 4, used);

      // Back-to-back reload on the last beat.
      load_run(8'd5, 8'd2, 2);
      push_beat(8'd9, 1'b1);
      in_valid = 1'b1;
      dIn      = 8'd9;
      nIn      = 8'd1;
      step();
      check("reload_not_ready", 32'(seen_in_ready), 32'(0));
      step();
      check("reload_ready", 32'(seen_in_ready), 32'(1));
      in_valid = 1'b0;
      step();
      check("reload_no_bubble", 32'(sb.size()), 32'(0));
      drain(0, 4, used);

      // Reset in the middle of an infinite run.
      load_run(8'h33, 8'd0, 0);
      for (int i = 0; i < 4; i++) begin
         push_beat(8'h33, 1'b0);
         step();
      end
      nrst = 1'b0;
      #1;
      check("midrst_valid", 32'(sOut_valid), 32'(0));
      check("midrst_busy", 32'(busy), 32'(0));
      check("midrst_in_ready", 32'(in_ready), 32'(1));
      check("midrst_last", 32'(sOut_last), 32'(0));
      sb.delete();
      prev_stall = 1'b0;
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      load_run(8'd3, 8'd1, 1);
      drain(0, 4, used);
      check("post_rst_cycles", 32'(used), 32'(1));

      // Stop while idle, and coincident with the load: both ignored.
      stop = 1'b1;
      step();
      load_run(8'h66, 8'd2, 2);
      stop = 1'b0;
      drain(0, 4, used);
      check("idle_stop_cycles", 32'(used), 32'(2));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
